// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ pulse-width receiver; decodes the first BITS bits after a latch gap.
// Define WS2812_RX_PASSTHRU_EN to forward the bits beyond BITS on dout like a chained LED.
module ws2812_rx #(
  parameter int BITS      = 24,
  parameter int T1_MIN    = 6,
  parameter int THIGH_MAX = 12,
  parameter int RESET_CYC = 500
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            din,
  output logic [BITS-1:0] data,
  output logic            data_rdy,
  output logic            err,
  output logic            dout
);

  localparam int CW = $clog2(RESET_CYC + 1);
  localparam int BW = $clog2(BITS + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] HI_ONE   = CW'(T1_MIN);
  localparam logic [CW-1:0] HI_MAX   = CW'(THIGH_MAX);
  localparam logic [CW-1:0] GAP_LAST = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] GAP      = CW'(RESET_CYC);
  localparam logic [BW-1:0] FULL     = BW'(BITS);

  localparam logic [2:0] WAITGAP = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] HIGH    = 3'd2;
  localparam logic [2:0] LOW     = 3'd3;
  localparam logic [2:0] LATCH   = 3'd4;

  logic [2:0]      state;
  logic            s1, s, s_prev;
  logic [CW-1:0]   hcnt, lcnt;
  logic [BW-1:0]   bcnt;
  logic            ovf;
  logic [BITS-1:0] sh;
  logic            rise, fall, bit_val;

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1     <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= din;
      s      <= s1;
      s_prev <= s;
    end
  end

  assign rise    = s & ~s_prev;
  assign fall    = ~s & s_prev;
  assign bit_val = (hcnt >= HI_ONE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= WAITGAP;
      hcnt     <= '0;
      lcnt     <= '0;
      bcnt     <= '0;
      ovf      <= 1'b0;
      // NOTE: sh is a plain register, not a RAM, so resetting it is cheap and keeps data clean.
      sh       <= '0;
      data     <= '0;
      data_rdy <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: strobes default low here, so no branch below has to clear them.
      data_rdy <= 1'b0;
      err      <= 1'b0;
      case (state)
        WAITGAP: begin
          if (s) begin
            lcnt <= '0;
          end else if (lcnt == GAP_LAST) begin
            lcnt  <= GAP;
            state <= IDLE;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        // Level test: a rise landing in the LATCH cycle must not be missed.
        IDLE: begin
          if (s) begin
            hcnt  <= CNT_ONE;
            bcnt  <= '0;
            ovf   <= 1'b0;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            if (!ovf && bcnt != FULL) begin
              sh   <= {sh[BITS-2:0], bit_val};
              bcnt <= bcnt + 1'b1;
            end else begin
              ovf <= 1'b1;
            end
            lcnt  <= CNT_ONE;
            state <= LOW;
          end else if (hcnt == HI_MAX) begin
            hcnt  <= hcnt + 1'b1;
            err   <= 1'b1;
            lcnt  <= '0;
            state <= WAITGAP;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            hcnt  <= CNT_ONE;
            state <= HIGH;
          end else if (lcnt == GAP_LAST) begin
            lcnt  <= GAP;
            state <= LATCH;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        LATCH: begin
          if (bcnt == FULL) begin
            data     <= sh;
            data_rdy <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          bcnt  <= '0;
          ovf   <= 1'b0;
          state <= IDLE;
        end
        default: state <= WAITGAP;
      endcase
    end
  end

`ifdef WS2812_RX_PASSTHRU_EN
  // Forward only while a bit past the first BITS is in flight; gaps and LATCH stay low.
  logic fwd;
  assign fwd = (ovf || bcnt == FULL) && (state == HIGH || state == LOW);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) dout <= 1'b0;
    else         dout <= fwd & s;
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812 receiver: samples the NRZ pulse-width LED stream, decodes the first BITS bits after each latch gap into a parallel word, and raises a one-cycle data_rdy strobe when a latch (reset) gap ends the frame. It is the receive-side counterpart of the team's WS2812 transmitter. It lets a tile act as a pixel in an LED chain, or loop back and check the transmitter's output on silicon.

## Interface
- BITS, 24: bits captured per frame (one pixel, GRB, MSB first).
- T1_MIN, 6: minimum high width in clk cycles decoded as '1'; shorter decodes as '0'.
- THIGH_MAX, 12: maximum legal high width in clk cycles; longer is a pulse error.
- RESET_CYC, 500: low width in clk cycles that marks a latch gap (50 us at 10 MHz).
- clk  input  1  system clock; all logic on rising edge.
- nreset  input  1  asynchronous, active-low reset.
- din  input  1  asynchronous WS2812 serial input.
- data  output  BITS  last complete frame; first received bit lands in data[BITS-1].
- data_rdy  output  1  one-cycle pulse when data is updated.
- err  output  1  one-cycle pulse on a pulse-width error or short frame.
- dout  output  1  forwarded stream (see Configuration).

## Operation
- din passes through a 2-FF synchronizer (s); all decoding uses s. Edges are found by comparing s with its previous value.
- Counters: hcnt (high width) and lcnt (low width) are both $clog2(RESET_CYC+1) bits and saturate. bcnt counts bits and saturates at BITS; a flag ovf is set once a bit arrives with bcnt==BITS.
- Shift register sh is BITS wide. Each decoded bit shifts in at the LSB; capture stops when bcnt==BITS.
- FSM states:
  - WAITGAP: entered on reset and after an error. lcnt counts while s==0; when lcnt reaches RESET_CYC, go to IDLE. A high level clears lcnt.
  - IDLE: s rises -> HIGH, with hcnt=1 and bcnt=0.
  - HIGH: hcnt increments each cycle s==1.
    - If hcnt exceeds THIGH_MAX: pulse err, go to WAITGAP, data unchanged.
    - On a falling edge, decode bit = (hcnt >= T1_MIN), then go to LOW with lcnt=1.
  - LOW: lcnt increments each cycle s==0.
    - Rising edge before RESET_CYC: go to HIGH with hcnt=1.
    - lcnt reaches RESET_CYC: go to LATCH.
  - LATCH (one cycle): if bcnt==BITS, data<=sh and data_rdy=1; otherwise err=1 (short frame). Then go to IDLE. Clear bcnt and ovf.
- Bits beyond BITS do not alter sh or data, and are not an error.

## Timing
- Reset values: data=0, data_rdy=0, err=0, dout=0; FSM in WAITGAP; all counters 0.
- Input latency: 2 clk cycles through the synchronizer.
- data_rdy and data update occur in the same cycle, exactly RESET_CYC+1 cycles after the last synchronized falling edge. data is held until the next successful latch.
- err fires in the cycle hcnt becomes THIGH_MAX+1, or in the LATCH cycle.
- data_rdy and err are never high together.
- Boundaries:
  - hcnt == T1_MIN decodes '1'; hcnt == THIGH_MAX is legal.
  - lcnt == RESET_CYC-1 followed by a rise is still an in-frame bit.
- nreset asserted mid-frame aborts immediately. The partial frame is discarded and the block waits for a full gap before accepting a new frame.

## Configuration
- WS2812_RX_PASSTHRU_EN defined:
  - dout reproduces s, registered one cycle, whenever ovf is set or the incoming bit has bcnt==BITS. The first BITS bits of each frame are consumed and the rest are forwarded, like a chained LED.
  - dout is 0 during the first BITS bits and during gaps.
- Not defined: dout tied to 0, and no forwarding logic is built.

## Test plan
- Reset, then a 600-cycle low gap, then 24 bits 0x123456 (high 4 cycles for '0', 8 for '1', 13-cycle period), then a 500-cycle low -> data=0x123456, data_rdy one pulse, err=0.
- Boundary widths: high 5 cycles -> '0', 6 -> '1', 12 -> '1', 13 -> err pulse, data unchanged, frame ignored until the next 500-cycle gap.
- Short frame: 10 bits, then a gap -> err pulse at LATCH, data_rdy=0, data keeps 0x123456.
- Two pixels 0xFF0000,0x00FF00 then a gap -> data=0xFF0000. With WS2812_RX_PASSTHRU_EN, dout carries only the 24 pulses of 0x00FF00 with widths preserved (±0 cycles); without it, dout stays 0.
- nreset pulsed after 12 bits -> outputs return to 0. The next frame starting within 500 cycles is ignored; a frame after a full gap decodes correctly.
- A low of 499 cycles between bits 11 and 12 -> treated as in-frame; the frame completes normally.
